// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: display reads win in active video,
// buffered camera writes fill every other slot on the port.
module fb_port_arbiter #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              display_enable,
    input  logic [11:0]       pixel_x,
    input  logic [11:0]       pixel_y,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              frame_start,
    output logic              busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        DISPLAY
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count, count_nxt;

    logic              boundary, active, display_now;
    logic              rd_issue, push, pop, rd_pipe;
    logic [ADDR_W-1:0] rd_addr;

    assign boundary = (pixel_x == '0) && (pixel_y == '0);
    assign active   = (pixel_x < 12'(H_ACTIVE)) && (pixel_y < 12'(V_ACTIVE));
    assign rd_addr  = ADDR_W'(pixel_y) * ADDR_W'(H_ACTIVE) + ADDR_W'(pixel_x);

    // The boundary cycle already belongs to the new mode, so the (0,0) read
    // is issued in the same cycle the state switches.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        display_now = (state == DISPLAY);
        if (boundary) begin
            display_now = display_enable;
            frame_start = display_enable;
            state_nxt   = display_enable ? DISPLAY : IDLE;
        end
        if (rst) begin
            display_now = 1'b0;
            frame_start = 1'b0;
        end

        rd_issue  = display_now && active;
        pop       = (count != '0) && !rd_issue;
        push      = wr_valid && wr_ready;

        bram_en   = rd_issue || pop;
        bram_we   = pop;
        bram_addr = '0;
        bram_din  = '0;
        if (rd_issue) begin
            bram_addr = rd_addr;
        end else if (pop) begin
            bram_addr = fifo_addr[rd_ptr];
            bram_din  = fifo_data[rd_ptr];
        end

        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_nxt = count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ready  <= 1'b0;
            busy      <= 1'b0;
            rd_pipe   <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            wr_ready  <= (count_nxt != (PTR_W+1)'(FIFO_DEPTH));
            busy      <= (count_nxt != '0);
            rd_pipe   <= rd_issue;
            pix_valid <= rd_pipe;
            pix_data  <= rd_pipe ? bram_dout : '0;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: a frame-level reference model predicts
// reads, pixel output and FIFO write drain order against a behavioural BRAM.
module tb_fb_port_arbiter;

    localparam int H     = 640;
    localparam int V     = 480;
    localparam int AW    = 19;
    localparam int DW    = 12;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          display_enable = 1'b1;
    logic [11:0]   pixel_x = 12'd100;
    logic [11:0]   pixel_y = 12'd50;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout = '0;
    logic [DW-1:0] pix_data;
    logic          pix_valid, frame_start, busy;

    fb_port_arbiter #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .display_enable(display_enable),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout),
        .pix_data(pix_data), .pix_valid(pix_valid),
        .frame_start(frame_start), .busy(busy)
    );

    always #20 clk = ~clk;

    // Behavioural single-port BRAM with one cycle of read latency.
    logic [DW-1:0] mem [H*V];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            else         bram_dout      <= mem[bram_addr];
        end
    end

    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct packed { logic v; logic [DW-1:0] d; } px_t;

    wr_t wq[$];     // accepted writes, in required drain order
    px_t pq[$];     // expected pixel output, two cycles behind the scan
    wr_t wsrc[$];   // writes waiting for the camera-side driver
    bit  disp_model = 1'b0;
    bit  first_clk  = 1'b1;
    int  errors = 0;
    int  checks = 0;

    int ys[6]     = '{0, 1, 200, 479, 480, 524};
    int seg_lo[5] = '{0, 318, 636, 640, 790};
    int seg_hi[5] = '{11, 322, 639, 655, 799};

    function automatic bit is_boundary();
        return (pixel_x == 12'd0) && (pixel_y == 12'd0);
    endfunction

    function automatic bit exp_read();
        bit on;
        if (rst) return 1'b0;
        on = is_boundary() ? display_enable : disp_model;
        return on && (int'(pixel_x) < H) && (int'(pixel_y) < V);
    endfunction

    function automatic int exp_addr();
        return int'(pixel_y) * H + int'(pixel_x);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t (x=%0d y=%0d): got %0h expected %0h",
                     name, $time, pixel_x, pixel_y, act, exp);
        end
    endtask

    // Producer: record what each finished cycle must lead to.
    initial begin
        forever begin
            px_t e;
            wr_t w;
            @(posedge clk);
            if (rst) begin
                wq.delete();
                pq.delete();
                pq.push_back('0);
                pq.push_back('0);
                disp_model = 1'b0;
                first_clk  = 1'b1;
            end else begin
                e.v = exp_read();
                e.d = e.v ? mem[exp_addr()] : '0;
                pq.push_back(e);
                if (wr_valid && wr_ready) begin
                    w.a = wr_addr;
                    w.d = wr_data;
                    wq.push_back(w);
                end
                if (is_boundary()) disp_model = display_enable;
                first_clk = 1'b0;
            end
        end
    end

    // Monitor: compare what the DUT presents this cycle.
    initial begin
        forever begin
            bit  er, ew;
            wr_t w;
            px_t p;
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs",
                    {bram_en, bram_we, pix_valid, frame_start, busy, wr_ready,
                     bram_addr, bram_din, pix_data}, '0);
            end else begin
                er = exp_read();
                ew = !er && (wq.size() != 0);
                chk("frame_start", frame_start, is_boundary() && display_enable);
                chk("read_issue", bram_en && !bram_we, er);
                if (er) chk("read_addr", bram_addr, exp_addr());
                chk("write_slot", bram_en && bram_we, ew);
                chk("busy", busy, wq.size() != 0);
                chk("wr_ready", wr_ready, !first_clk && (wq.size() != DEPTH));
                if (bram_en && bram_we) begin
                    if (wq.size() == 0) begin
                        chk("write_unexpected", 1, 0);
                    end else begin
                        w = wq.pop_front();
                        chk("write_addr", bram_addr, w.a);
                        chk("write_data", bram_din, w.d);
                    end
                end
                if (pq.size() == 0) begin
                    chk("pix_queue_empty", 1, 0);
                end else begin
                    p = pq.pop_front();
                    chk("pix_valid", pix_valid, p.v);
                    chk("pix_data", pix_data, p.d);
                end
            end
        end
    end

    task automatic step(input int x, input int y, input logic de, input logic r);
        bit  acc;
        wr_t w;
        @(negedge clk);
        acc = wr_valid && wr_ready;
        @(posedge clk);
        #1;
        rst            = r;
        pixel_x        = 12'(x);
        pixel_y        = 12'(y);
        display_enable = de;
        if (acc) wr_valid = 1'b0;
        if (!wr_valid && wsrc.size() != 0) begin
            w        = wsrc.pop_front();
            wr_valid = 1'b1;
            wr_addr  = w.a;
            wr_data  = w.d;
        end
    endtask

    task automatic push_rand();
        wr_t w;
        w.a = AW'($urandom_range(H*V-1));
        w.d = DW'($urandom);
        wsrc.push_back(w);
    endtask

    task automatic run_frame(input bit en, input bit jitter, input int pct, input bit burst,
                             input bit drop, input int rst_line, input bit idle_wr);
        logic cur;
        wr_t  w;
        cur = en;
        foreach (ys[i]) begin
            for (int s = 0; s < 5; s++) begin
                for (int x = seg_lo[s]; x <= seg_hi[s]; x++) begin
                    logic de, r;
                    if (drop && ys[i] == 200 && x == 320) cur = 1'b0;
                    de = cur;
                    if (jitter) de = 1'($urandom);
                    if (x == 0 && ys[i] == 0) de = en;
                    r = (ys[i] == rst_line) && (x >= 5) && (x < 8);
                    if (burst && ys[i] == 1 && x == 0) repeat (10) push_rand();
                    if (idle_wr && ys[i] == 0 && x == 2) begin
                        w.a = AW'(32'h100);
                        w.d = DW'(32'hABC);
                        wsrc.push_back(w);
                    end
                    if (pct > 0 && int'($urandom_range(99)) < pct) push_rand();
                    step(x, ys[i], de, r);
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < H*V; a++) mem[a] = DW'((a * 37) ^ (a >> 5));

        // Reset mid-frame, release with display requested: nothing until (0,0).
        for (int k = 0; k < 3; k++)  step(100 + k, 50, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) step(103 + k, 50, 1'b1, 1'b0);
        for (int x = 630; x < 650; x++) step(x, 479, 1'b1, 1'b0);

        run_frame(1'b1, 1'b0, 0,  1'b1, 1'b0, -1,  1'b0);
        run_frame(1'b1, 1'b0, 30, 1'b0, 1'b1, -1,  1'b0);
        run_frame(1'b0, 1'b0, 20, 1'b0, 1'b0, -1,  1'b1);
        run_frame(1'b1, 1'b1, 50, 1'b0, 1'b0, 200, 1'b0);
        run_frame(1'b1, 1'b1, 60, 1'b1, 1'b0, -1,  1'b0);
        run_frame(1'b0, 1'b0, 0,  1'b0, 1'b0, -1,  1'b0);
        for (int k = 0; k < 5; k++) step(700, 500, 1'b0, 1'b0);

        @(negedge clk);
        chk("fifo_drained", wq.size() + wsrc.size() + int'(wr_valid), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
